imem_program_loader: RTL and testbench

- Writer-side counterpart to the processor's instruction fetch path: streams a program image from a byte-wide valid/ready source into the instruction memory write port.
- Holds the processor in reset until the image is fully written, then releases it so execution starts from BASE_ADDR.
- Sits between the bench/host byte source and the RISC_V_Processor's instruction memory and reset input.

---
 rtl/imem_program_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_program_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader
// Streams a length-prefixed program image from a byte-wide valid/ready
// source into the instruction memory write port. The processor is held in
// reset until the whole image has been written, and is then released so it
// begins fetching at BASE_ADDR.
//
// Stream format: 16-bit word count N (low byte first), then 4*N instruction
// bytes, little-endian within each word.
//
// Ports:
//   clk          system clock, rising-edge
//   reset        asynchronous active-high reset
//   start        one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid     source byte valid
//   in_byte      source byte
//   in_ready     loader accepts a byte this cycle (combinational from state)
//   mem_we       instruction memory write enable, one cycle per word
//   mem_addr     byte address of the word being written
//   mem_wdata    instruction word being written
//   cpu_reset    active-high reset to the processor
//   done         image loaded, processor released
//   error        length header exceeded DEPTH_WORDS
//   words_loaded words written in the current load
module imem_program_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    // Word index must be able to hold DEPTH_WORDS itself (the value it takes
    // right after the last write of a full-size image).
    localparam int          WIDX_W  = $clog2(DEPTH_WORDS + 1);
    localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          len_lo;
    logic [15:0]         len;
    logic [15:0]         len_full;
    logic [1:0]          byte_idx;
    logic [23:0]         asm_word;
    logic [WIDX_W-1:0]   word_idx;
    logic [WIDX_W-1:0]   widx_inc;

    // Full header as seen while the high byte is on the bus.
    assign len_full = {in_byte, len_lo};
    assign widx_inc = word_idx + WIDX_W'(1);

    // Next-state and handshake
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_full > DEPTH_N)       state_next = S_ERROR;
                    else if (len_full == 16'd0)   state_next = S_DONE;
                    else                          state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (16'(widx_inc) == len) state_next = S_DONE;
                else                      state_next = S_DATA;
            end
            S_DONE, S_ERROR: begin
                if (start) state_next = S_LEN_LO;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            asm_word     <= 24'd0;
            word_idx     <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 32'd0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state     <= state_next;
            mem_we    <= 1'b0;
            // Status flags track the state being entered so they change on
            // the same edge as the state itself.
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERROR);
            cpu_reset <= (state_next != S_DONE);

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        words_loaded <= 16'd0;
                        word_idx     <= '0;
                        byte_idx     <= 2'd0;
                    end
                end
                S_LEN_LO: begin
                    if (in_valid) len_lo <= in_byte;
                end
                S_LEN_HI: begin
                    if (in_valid) begin
                        len          <= len_full;
                        byte_idx     <= 2'd0;
                        word_idx     <= '0;
                        words_loaded <= 16'd0;
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= in_byte;
                            2'd1: asm_word[15:8]  <= in_byte;
                            2'd2: asm_word[23:16] <= in_byte;
                            default: begin
                                // Last byte goes straight into the write
                                // word so mem_we rises on this same edge.
                                mem_we    <= 1'b1;
                                mem_wdata <= {in_byte, asm_word};
                                mem_addr  <= BASE_ADDR + 64'({word_idx, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx     <= widx_inc;
                    words_loaded <= words_loaded + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wa[$];
    logic [31:0] wd[$];

    imem_program_loader #(.DEPTH_WORDS(64), .BASE_ADDR(64'h0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen between rising edges.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte
    // was accepted, leaving in_valid high for back-to-back streaming.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte timeout: in_ready=%0b want 1", in_ready);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_two_word_image(input string tag);
        n_cmp++;
        if (wa.size() !== 2) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d want 2", tag, wa.size());
        end else begin
            n_cmp++;
            if (wa[0] !== 64'h0 || wd[0] !== 32'h00A00513) begin
                n_bad++;
                $display("FAIL %s word0: got %h/%h want 0/00a00513", tag, wa[0], wd[0]);
            end
            n_cmp++;
            if (wa[1] !== 64'h4 || wd[1] !== 32'h00B00593) begin
                n_bad++;
                $display("FAIL %s word1: got %h/%h want 4/00b00593", tag, wa[1], wd[1]);
            end
        end
        n_cmp++;
        if ({done, cpu_reset, error} !== 3'b100 || words_loaded !== 16'd2) begin
            n_bad++;
            $display("FAIL %s final: done/cpu_reset/error=%b words=%0d want 100 words=2",
                     tag, {done, cpu_reset, error}, words_loaded);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, cpu_reset, done, error} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00100", {in_ready, mem_we, cpu_reset, done, error});
        end
        n_cmp++;
        if (mem_addr !== 64'h0 || mem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h want 0 0 0", mem_addr, mem_wdata, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
        // IDLE: not ready, processor held
        n_cmp++;
        if ({in_ready, cpu_reset} !== 2'b01) begin
            n_bad++;
            $display("FAIL idle: in_ready/cpu_reset=%b want 01", {in_ready, cpu_reset});
        end
    endtask

    task automatic test_basic();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        // One cycle after the fourth byte's accepting edge the write is up.
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 64'h0 || mem_wdata !== 32'h00A00513 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency: we=%b addr=%h data=%h rdy=%b want 1 0 00a00513 0",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        n_cmp++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_midload: cpu_reset=%b done=%b want 1 0", cpu_reset, done);
        end
        send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
        idle_cycles(3);
        check_two_word_image("basic");
        // Address/data hold once the write is over.
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 64'h4 || mem_wdata !== 32'h00B00593) begin
            n_bad++;
            $display("FAIL basic_hold: we=%b addr=%h data=%h want 0 4 00b00593", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_stall();
        wa.delete(); wd.delete();
        pulse_start();
        n_cmp++;
        if ({done, cpu_reset, error} !== 3'b010 || words_loaded !== 16'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL restart: done/cpu_reset/error=%b words=%0d rdy=%b want 010 0 1",
                     {done, cpu_reset, error}, words_loaded, in_ready);
        end
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05);
        idle_cycles(3);
        send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
        idle_cycles(3);
        check_two_word_image("stall");
    endtask

    task automatic test_error_and_zero();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h41); send_byte(8'h00);
        idle_cycles(1);
        n_cmp++;
        if ({error, cpu_reset, in_ready, done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL error_state: error/cpu_reset/rdy/done=%b want 1100", {error, cpu_reset, in_ready, done});
        end
        // Offered bytes are ignored while in ERROR.
        in_valid = 1'b1; in_byte = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (error !== 1'b1 || wa.size() !== 0) begin
            n_bad++;
            $display("FAIL error_hold: error=%b writes=%0d want 1 0", error, wa.size());
        end
        pulse_start();
        n_cmp++;
        if (error !== 1'b0 || in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL error_clear: error=%b rdy=%b cpu_reset=%b want 0 1 1", error, in_ready, cpu_reset);
        end
        send_byte(8'h00); send_byte(8'h00);
        idle_cycles(2);
        n_cmp++;
        if ({done, cpu_reset, error} !== 3'b100 || words_loaded !== 16'd0 || wa.size() !== 0) begin
            n_bad++;
            $display("FAIL zero_len: done/cpu_reset/error=%b words=%0d writes=%0d want 100 0 0",
                     {done, cpu_reset, error}, words_loaded, wa.size());
        end
    endtask

    task automatic test_full_depth();
        logic [7:0]  b;
        logic [31:0] exp_w;
        int          bad_words = 0;
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h40); send_byte(8'h00);
        for (int k = 0; k < 256; k++) begin
            b = 8'(k);
            send_byte(b);
        end
        idle_cycles(3);
        n_cmp++;
        if (wa.size() !== 64) begin
            n_bad++;
            $display("FAIL full_count: got %0d want 64", wa.size());
        end else begin
            for (int w = 0; w < 64; w++) begin
                exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
                if (wa[w] !== 64'(4*w) || wd[w] !== exp_w) bad_words++;
            end
            n_cmp++;
            if (bad_words != 0) begin
                n_bad++;
                $display("FAIL full_words: %0d bad words, want 0", bad_words);
            end
            n_cmp++;
            if (wa[63] !== 64'hFC || wd[63] !== 32'hFFFEFDFC) begin
                n_bad++;
                $display("FAIL full_last: got %h/%h want fc/fffefdfc", wa[63], wd[63]);
            end
        end
        n_cmp++;
        if ({done, cpu_reset} !== 2'b10 || words_loaded !== 16'd64) begin
            n_bad++;
            $display("FAIL full_done: done/cpu_reset=%b words=%0d want 10 64", {done, cpu_reset}, words_loaded);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h05);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, mem_we, cpu_reset, done, error} !== 5'b00100 ||
            mem_addr !== 64'h0 || mem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mid: ctrl=%b addr=%h data=%h words=%0d want 00100 0 0 0",
                     {in_ready, mem_we, cpu_reset, done, error}, mem_addr, mem_wdata, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
        idle_cycles(3);
        check_two_word_image("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_error_and_zero();
        test_full_depth();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
